avl_bus_12n: RTL and testbench
==============================

# avl_bus_12n

Address-decoding 1-to-N Avalon-style router that sits directly downstream of the N-to-1 arbiter. It takes the single arbitrated master stream and forwards each command to one of `SLAVE_NUM` slave ports, or to an internal error responder for unmapped addresses. It tracks outstanding reads and returns read data to the master strictly in issue order. Write bursts are locked to one slave for their full length.

## Interface
- `SLAVE_NUM`, 4: number of slave ports, 1..8.
- `SLAVE_BASE`, packed `SLAVE_NUM*32` bits, slave k at bits `[k*32+:32]`: base address per slave.
- `SLAVE_MASK`, packed `SLAVE_NUM*32` bits: address mask per slave. Slave k hits when `(address & mask_k) == base_k`. Lowest k wins on overlap.
- `SEL_FIFO_DEPTH`, 4: outstanding read-command entries. Power of two, ≥2.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned for unmapped reads.
- `clk`, input, 1: clock, all state on rising edge.
- `rest`, input, 1: asynchronous active-low reset.
- `avl_in`, `i_avl_bus.slave`, -: upstream port driven by the arbiter output. Fields:
  - address 32
  - byte_en 4
  - read, write 1
  - write_data 32
  - begin_burst_transfer 1
  - burst_count 8
  - resp_ready 1
  - read_data 32
  - read_data_valid 1
  - request_ready 1
- `avl_out[SLAVE_NUM-1:0]`, `i_avl_bus.master`, -: one port per slave, same fields.

## Operation
- **Decode.** `dsel` = first matching slave index, else `ERR` (virtual index `SLAVE_NUM`).
  - While in WR_BURST, `sel` = locked index; otherwise `sel = dsel`.
- **Command path (combinational).**
  - address, byte_en, write_data, burst_count are broadcast to all slaves.
  - read, write and begin_burst_transfer are asserted only on `avl_out[sel]`, gated by `issue_ok`.
- **`issue_ok`.**
  - Writes: always 1.
  - Reads: fifo not full AND (fifo empty OR `sel` == sel of the most recently pushed entry). This same-target rule guarantees in-order responses.
- **`avl_in.request_ready`.**
  - `sel` is a slave: `avl_out[sel].request_ready && issue_ok`.
  - `sel == ERR`: `issue_ok`, i.e. accepted immediately.
- **Read tracking.** On each accepted read, push {sel, beats} into the sel fifo.
  - beats = burst_count when begin_burst_transfer is 1, else 1.
  - burst_count 0 is treated as 1.
- **Response path.**
  - Head entry index h. A head beat counter `rem` loads from the entry.
  - `avl_in.read_data` and `avl_in.read_data_valid` come from `avl_out[h]`.
  - If h is `ERR`: read_data = `ERR_DATA`, read_data_valid = 1.
  - read_data_valid is forced to 0 when the fifo is empty.
  - `avl_out[k].resp_ready = avl_in.resp_ready && !empty && k == h`. All other slaves see 0.
- **Head retirement.** On a valid && resp_ready beat, `rem` decrements. When the last beat is accepted, the entry pops.
- **Write FSM.**
  - IDLE → WR_BURST on an accepted write with begin_burst_transfer and burst_count > 1. Latch sel; set `wcnt = burst_count - 1`.
  - In WR_BURST, each accepted write beat decrements `wcnt`. Address is ignored for routing.
  - WR_BURST → IDLE when the beat with `wcnt == 1` is accepted.
  - A read presented during WR_BURST is not accepted (request_ready = 0).

## Timing
- Command path: 0-cycle latency. Accept is the same cycle as valid && request_ready.
- A fifo push is visible to the issue check and to the response head on the next cycle.
- Response path: 0-cycle pass-through. An ERR response is available the cycle after its push.
- Full fifo: a read is held off even if a pop occurs in the same cycle. Push and pop in the same cycle are legal when the fifo is not full.
- Same-cycle pop of the head and push of a new entry to a different slave is not allowed. The push check uses the pre-pop state.
- Reset (rest low, asynchronous):
  - fifo empty, `rem` = 0, FSM in IDLE, `wcnt` = 0.
  - All `avl_out[k]` read, write, begin_burst_transfer and resp_ready evaluate to 0 when upstream read and write are 0.
  - `avl_in.read_data_valid` = 0.
  - Reset asserted mid-burst abandons the burst. Outstanding responses are discarded.
- Fifo pointers wrap modulo `SEL_FIFO_DEPTH`. The count is one bit wider, so full and empty are distinguishable.

## Test plan
- **Single read to slave 1** (base 0x1000_0000, mask 0xF000_0000), slave returns 0x1234_5678 after 3 cycles.
  - `avl_out[1].read` pulses one cycle; no other slave is strobed.
  - `avl_in` sees read_data_valid with 0x1234_5678 exactly when slave 1 asserts it.
- **Back-to-back reads, slave 0 then slave 2.**
  - The slave 2 read is held (request_ready = 0) until slave 0's beat is accepted.
  - Responses arrive in order 0 then 2.
- **Four pipelined reads to slave 0 with SEL_FIFO_DEPTH = 4, resp_ready held low.**
  - Fifth read is stalled.
  - Raising resp_ready drains 4 beats in order; the fifth read is then accepted.
- **Write burst, burst_count = 4, to slave 3, with beats 2–4 carrying an address that decodes to slave 0.**
  - All 4 beats reach slave 3.
  - FSM returns to IDLE after beat 4.
  - A read presented during the burst is not accepted until the burst ends.
- **Read burst of 2 to unmapped address 0xF000_0000.**
  - Accepted the same cycle.
  - Two beats of 0xDEAD_BEEF are returned, honouring resp_ready back-pressure.
- **Reset asserted with 2 outstanding reads.**
  - fifo is empty immediately and read_data_valid = 0.
  - A subsequent read to slave 1 completes normally.

Source files
------------

// File: rtl/avl_bus_12n_if.sv
// avl_bus_12n_if: Avalon-style command/response bundle shared by the router's upstream and slave ports
interface i_avl_bus;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic        begin_burst_transfer;
  logic [7:0]  burst_count;
  logic        resp_ready;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        request_ready;
  modport master (
    output address, byte_en, read, write, write_data, begin_burst_transfer, burst_count, resp_ready,
    input  read_data, read_data_valid, request_ready
  );
  modport slave (
    input  address, byte_en, read, write, write_data, begin_burst_transfer, burst_count, resp_ready,
    output read_data, read_data_valid, request_ready
  );
endinterface

// File: rtl/avl_bus_12n.sv
// avl_bus_12n: address-decoding 1-to-N Avalon router with in-order read return,
// an error responder for unmapped addresses and write-burst target locking
module avl_bus_12n #(
  parameter int                      SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM*32-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*32-1:0] SLAVE_MASK     = {4{32'hF000_0000}},
  parameter int                      SEL_FIFO_DEPTH = 4,
  parameter logic [31:0]             ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic       clk,
  input logic       rest,
  i_avl_bus.slave   avl_in,
  i_avl_bus.master  avl_out [SLAVE_NUM]
);
  localparam int SW = $clog2(SLAVE_NUM + 1);
  localparam int NP = 1 << SW;
  localparam int AW = $clog2(SEL_FIFO_DEPTH);
  localparam logic [SW-1:0] ERR = SW'(SLAVE_NUM);
  typedef enum logic {IDLE, WR_BURST} state_t;
  state_t state;
  logic [SW-1:0] dsel, sel, lock, last, h;
  logic [7:0] wcnt, rem, eff, beats;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [SW-1:0] sel_q [SEL_FIFO_DEPTH];
  logic [7:0] beats_q [SEL_FIFO_DEPTH];
  logic empty, full, rd_ok, issue_ok, cmd, push, beat, pop;
  logic [SLAVE_NUM-1:0] s_rdy, s_vld;
  logic [31:0] s_dat [SLAVE_NUM];
  logic [NP-1:0] rdy_x, vld_x;
  logic [31:0] dat_x [NP];
  always_comb begin
    dsel = ERR;
    for (int k = SLAVE_NUM - 1; k >= 0; k--)
      if ((avl_in.address & SLAVE_MASK[k*32+:32]) == SLAVE_BASE[k*32+:32]) dsel = SW'(k);
  end
  assign empty    = cnt == '0;
  assign full     = cnt == (AW+1)'(SEL_FIFO_DEPTH);
  assign sel      = state == WR_BURST ? lock : dsel;
  assign h        = sel_q[rp];
  // a read may only join the queue behind entries for the same target, keeping returns in order
  assign rd_ok    = state == IDLE && !full && (empty || sel == last);
  assign issue_ok = avl_in.write || rd_ok;
  assign cmd      = avl_in.read || avl_in.write;
  assign rdy_x    = NP'({1'b1, s_rdy});
  assign vld_x    = NP'({1'b1, s_vld});
  always_comb begin
    for (int i = 0; i < NP; i++) dat_x[i] = ERR_DATA;
    for (int i = 0; i < SLAVE_NUM; i++) dat_x[i] = s_dat[i];
  end
  assign avl_in.request_ready   = rdy_x[sel] && issue_ok;
  assign avl_in.read_data       = dat_x[h];
  assign avl_in.read_data_valid = !empty && vld_x[h];
  for (genvar k = 0; k < SLAVE_NUM; k++) begin : g_out
    assign avl_out[k].address              = avl_in.address;
    assign avl_out[k].byte_en              = avl_in.byte_en;
    assign avl_out[k].write_data           = avl_in.write_data;
    assign avl_out[k].burst_count          = avl_in.burst_count;
    assign avl_out[k].read                 = avl_in.read && rd_ok && sel == SW'(k);
    assign avl_out[k].write                = avl_in.write && sel == SW'(k);
    assign avl_out[k].begin_burst_transfer = avl_in.begin_burst_transfer && cmd && issue_ok && sel == SW'(k);
    assign avl_out[k].resp_ready           = avl_in.resp_ready && !empty && h == SW'(k);
    assign s_rdy[k] = avl_out[k].request_ready;
    assign s_vld[k] = avl_out[k].read_data_valid;
    assign s_dat[k] = avl_out[k].read_data;
  end
  assign push  = avl_in.read && rd_ok && rdy_x[sel];
  assign beats = avl_in.begin_burst_transfer && avl_in.burst_count != 8'd0 ? avl_in.burst_count : 8'd1;
  // rem == 0 means the head entry has not started yet, so its full beat count applies
  assign eff   = rem != 8'd0 ? rem : beats_q[rp];
  assign beat  = avl_in.read_data_valid && avl_in.resp_ready;
  assign pop   = beat && eff == 8'd1;
  always_ff @(posedge clk) begin
    if (push) begin
      sel_q[wp]   <= sel;
      beats_q[wp] <= beats;
    end
  end
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      rem  <= '0;
      last <= '0;
    end else begin
      if (push) begin
        wp   <= wp + AW'(1);
        last <= sel;
      end
      if (pop) rp <= rp + AW'(1);
      if (beat) rem <= eff - 8'd1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
      wcnt  <= '0;
      lock  <= '0;
    end else if (avl_in.write && avl_in.request_ready) begin
      if (state == IDLE && avl_in.begin_burst_transfer && avl_in.burst_count > 8'd1) begin
        state <= WR_BURST;
        lock  <= sel;
        wcnt  <= avl_in.burst_count - 8'd1;
      end else if (state == WR_BURST) begin
        wcnt  <= wcnt - 8'd1;
        state <= wcnt == 8'd1 ? IDLE : WR_BURST;
      end
    end
  end
endmodule

// File: tb/tb_avl_bus_12n.sv
// tb_avl_bus_12n: directed checks of routing, in-order read return, error responder,
// write-burst locking and reset behaviour against simple latency-based slave models
module tb_avl_bus_12n;
  localparam int LAT = 3;
  logic clk = 0;
  logic rest = 0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rx_n = 0;
  logic [31:0] rx [64];
  logic [31:0] sdat [4];
  logic [3:0] s_rdy = 4'hF;
  logic [3:0] rd_s, wr_s, bb_s, rr_s, vd_s;
  i_avl_bus up();
  i_avl_bus dn[4]();
  avl_bus_12n dut (.clk(clk), .rest(rest), .avl_in(up), .avl_out(dn));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (up.read_data_valid && up.resp_ready) begin
      rx[rx_n % 64] <= up.read_data;
      rx_n <= rx_n + 1;
    end
  for (genvar k = 0; k < 4; k++) begin : g_sl
    logic [31:0] md [16];
    int mt [16];
    int mh = 0, mw = 0, rc = 0, wc = 0;
    logic [31:0] wl = 0;
    assign dn[k].request_ready   = s_rdy[k];
    assign dn[k].read_data_valid = mh != mw && cyc >= mt[mh % 16];
    assign dn[k].read_data       = md[mh % 16];
    assign rd_s[k] = dn[k].read;
    assign wr_s[k] = dn[k].write;
    assign bb_s[k] = dn[k].begin_burst_transfer;
    assign rr_s[k] = dn[k].resp_ready;
    assign vd_s[k] = dn[k].read_data_valid;
    always @(posedge clk or negedge rest)
      if (!rest) begin
        mh <= 0;
        mw <= 0;
      end else begin
        if (dn[k].read && dn[k].request_ready) begin
          md[mw % 16] <= sdat[k];
          mt[mw % 16] <= cyc + LAT;
          mw <= mw + 1;
          rc <= rc + 1;
        end
        if (dn[k].read_data_valid && dn[k].resp_ready) mh <= mh + 1;
        if (dn[k].write && dn[k].request_ready) begin
          wc <= wc + 1;
          wl <= dn[k].write_data;
        end
      end
  end

  task automatic idle();
    up.read = 0; up.write = 0; up.begin_burst_transfer = 0; up.burst_count = 0;
    up.address = 0; up.write_data = 0; up.byte_en = 4'hF;
  endtask

  task automatic cmd(input logic r, input logic w, input logic [31:0] a, input logic b, input logic [7:0] bc, input logic [31:0] wd);
    up.read = r; up.write = w; up.address = a; up.begin_burst_transfer = b; up.burst_count = bc; up.write_data = wd;
  endtask

  task automatic test_reset();
    idle();
    up.resp_ready = 1;
    rest = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (up.read_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", up.read_data_valid); end
    checks++; if ({rd_s, wr_s, bb_s, rr_s} !== 16'h0) begin errors++; $display("FAIL reset_strobes got %h exp 0000", {rd_s, wr_s, bb_s, rr_s}); end
    checks++; if (dut.cnt !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", dut.cnt); end
    @(negedge clk) rest = 1;
  endtask

  task automatic test_single_read();
    int b = rx_n;
    int r1 = g_sl[1].rc;
    int ro = g_sl[0].rc + g_sl[2].rc + g_sl[3].rc;
    int n = 0;
    bit ok = 1;
    up.resp_ready = 1;
    sdat[1] = 32'h1234_5678;
    @(negedge clk); cmd(1, 0, 32'h1000_0010, 0, 0, 0); #1;
    checks++; if (rd_s !== 4'b0010) begin errors++; $display("FAIL single_strobe got %b exp 0010", rd_s); end
    checks++; if (up.request_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", up.request_ready); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_s !== 4'b0000) begin errors++; $display("FAIL single_pulse got %b exp 0000", rd_s); end
    while (rx_n == b && n < 20) begin
      if (up.read_data_valid !== vd_s[1]) ok = 0;
      @(negedge clk); #1; n++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_passthrough got mismatch exp valid equal to slave 1 valid"); end
    checks++; if (rx_n - b != 1 || rx[b % 64] !== 32'h1234_5678) begin errors++; $display("FAIL single_data got %0d beats %h exp 1 beat 12345678", rx_n - b, rx[b % 64]); end
    checks++; if (g_sl[1].rc - r1 != 1 || g_sl[0].rc + g_sl[2].rc + g_sl[3].rc != ro) begin errors++; $display("FAIL single_route got s1=%0d exp 1 other slaves untouched", g_sl[1].rc - r1); end
    checks++; if (up.read_data_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", up.read_data_valid); end
  endtask

  task automatic test_back_to_back();
    int b = rx_n;
    int n = 0;
    up.resp_ready = 1;
    sdat[0] = 32'hA0;
    sdat[2] = 32'hC2;
    @(negedge clk); cmd(1, 0, 32'h0000_0100, 0, 0, 0); #1;
    checks++; if (up.request_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b exp 1", up.request_ready); end
    @(negedge clk); cmd(1, 0, 32'h2000_0000, 0, 0, 0); #1;
    checks++; if (up.request_ready !== 1'b0 || rd_s !== 4'b0000) begin errors++; $display("FAIL b2b_hold got ready=%b strobes=%b exp 0 0000", up.request_ready, rd_s); end
    while (up.request_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL b2b_timeout got no ready exp ready within 20 cycles"); end
    checks++; if (rx_n - b != 1) begin errors++; $display("FAIL b2b_first_done got %0d beats exp 1", rx_n - b); end
    checks++; if (rd_s !== 4'b0100) begin errors++; $display("FAIL b2b_second_strobe got %b exp 0100", rd_s); end
    @(negedge clk); idle();
    n = 0;
    while (rx_n - b < 2 && n < 20) begin @(negedge clk); n++; end
    #1;
    checks++; if (rx[b % 64] !== 32'hA0 || rx[(b + 1) % 64] !== 32'hC2) begin errors++; $display("FAIL b2b_order got %h %h exp a0 c2", rx[b % 64], rx[(b + 1) % 64]); end
  endtask

  task automatic test_pipelined();
    int b = rx_n;
    int n = 0;
    bit ok = 1;
    up.resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sdat[0] = 32'h100 + 32'(i); cmd(1, 0, 32'(i * 4), 0, 0, 0); #1;
      checks++; if (up.request_ready !== 1'b1) begin errors++; $display("FAIL pipe_ready_%0d got %b exp 1", i, up.request_ready); end
    end
    @(negedge clk); sdat[0] = 32'h104; cmd(1, 0, 32'h10, 0, 0, 0); #1;
    checks++; if (up.request_ready !== 1'b0) begin errors++; $display("FAIL pipe_full_stall got %b exp 0", up.request_ready); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (up.request_ready !== 1'b0 || rd_s !== 4'b0000) begin errors++; $display("FAIL pipe_still_stalled got ready=%b strobes=%b exp 0 0000", up.request_ready, rd_s); end
    checks++; if (up.read_data_valid !== 1'b1 || up.read_data !== 32'h100) begin errors++; $display("FAIL pipe_head got %b %h exp 1 00000100", up.read_data_valid, up.read_data); end
    up.resp_ready = 1;
    while (up.request_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20 || rx_n - b < 1) begin errors++; $display("FAIL pipe_release got %0d beats before accept exp at least 1", rx_n - b); end
    @(negedge clk); idle();
    n = 0;
    while (rx_n - b < 5 && n < 30) begin @(negedge clk); n++; end
    #1;
    for (int i = 0; i < 5; i++) if (rx[(b + i) % 64] !== 32'h100 + 32'(i)) ok = 0;
    checks++; if (!ok || rx_n - b != 5) begin errors++; $display("FAIL pipe_order got %0d beats first %h exp 5 beats 100..104 in order", rx_n - b, rx[b % 64]); end
  endtask

  task automatic test_write_burst();
    int b = rx_n;
    int w3 = g_sl[3].wc;
    int w0 = g_sl[0].wc;
    int n = 0;
    up.resp_ready = 1;
    sdat[1] = 32'h5A5A;
    @(negedge clk); cmd(0, 1, 32'h3000_0000, 1, 4, 32'h30); #1;
    checks++; if (wr_s !== 4'b1000 || bb_s !== 4'b1000) begin errors++; $display("FAIL burst_beat1 got wr=%b bbt=%b exp 1000 1000", wr_s, bb_s); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); cmd(0, 1, 32'h0000_0000, 0, 4, 32'h30 + 32'(i)); #1;
      checks++; if (wr_s !== 4'b1000) begin errors++; $display("FAIL burst_locked_%0d got %b exp 1000", i, wr_s); end
      if (i == 1) begin
        @(negedge clk); cmd(1, 0, 32'h1000_0000, 0, 0, 0); #1;
        checks++; if (up.request_ready !== 1'b0 || rd_s !== 4'b0000) begin errors++; $display("FAIL burst_read_blocked got ready=%b strobes=%b exp 0 0000", up.request_ready, rd_s); end
      end
    end
    @(negedge clk); cmd(1, 0, 32'h1000_0000, 0, 0, 0); #1;
    checks++; if (up.request_ready !== 1'b1 || rd_s !== 4'b0010) begin errors++; $display("FAIL burst_idle_read got ready=%b strobes=%b exp 1 0010", up.request_ready, rd_s); end
    @(negedge clk); idle(); #1;
    checks++; if (g_sl[3].wc - w3 != 4 || g_sl[0].wc != w0 || g_sl[3].wl !== 32'h33) begin errors++; $display("FAIL burst_counts got s3=%0d s0=%0d last=%h exp 4 0 00000033", g_sl[3].wc - w3, g_sl[0].wc - w0, g_sl[3].wl); end
    while (rx_n == b && n < 20) begin @(negedge clk); n++; end
    #1;
    checks++; if (rx_n - b != 1 || rx[b % 64] !== 32'h5A5A) begin errors++; $display("FAIL burst_read_data got %0d beats %h exp 1 beat 00005a5a", rx_n - b, rx[b % 64]); end
  endtask

  task automatic test_err_burst();
    int b = rx_n;
    up.resp_ready = 0;
    @(negedge clk); cmd(1, 0, 32'hF000_0000, 1, 2, 0); #1;
    checks++; if (up.request_ready !== 1'b1 || rd_s !== 4'b0000) begin errors++; $display("FAIL err_accept got ready=%b strobes=%b exp 1 0000", up.request_ready, rd_s); end
    @(negedge clk); idle(); #1;
    checks++; if (up.read_data_valid !== 1'b1 || up.read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_beat1 got %b %h exp 1 deadbeef", up.read_data_valid, up.read_data); end
    @(negedge clk); #1;
    checks++; if (rx_n != b || up.read_data_valid !== 1'b1) begin errors++; $display("FAIL err_backpressure got beats=%0d valid=%b exp 0 1", rx_n - b, up.read_data_valid); end
    up.resp_ready = 1;
    @(negedge clk); #1;
    checks++; if (rx_n - b != 1) begin errors++; $display("FAIL err_one_beat got %0d exp 1", rx_n - b); end
    up.resp_ready = 0;
    @(negedge clk); #1;
    checks++; if (rx_n - b != 1 || up.read_data_valid !== 1'b1) begin errors++; $display("FAIL err_beat2_held got beats=%0d valid=%b exp 1 1", rx_n - b, up.read_data_valid); end
    up.resp_ready = 1;
    @(negedge clk); #1;
    checks++; if (rx_n - b != 2 || up.read_data_valid !== 1'b0) begin errors++; $display("FAIL err_done got beats=%0d valid=%b exp 2 0", rx_n - b, up.read_data_valid); end
    checks++; if (rx[b % 64] !== 32'hDEAD_BEEF || rx[(b + 1) % 64] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_data got %h %h exp deadbeef deadbeef", rx[b % 64], rx[(b + 1) % 64]); end
  endtask

  task automatic test_reset_outstanding();
    int b = rx_n;
    int n = 0;
    up.resp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); sdat[0] = 32'h200 + 32'(i); cmd(1, 0, 32'h0000_0040, 0, 0, 0);
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (up.read_data_valid !== 1'b1) begin errors++; $display("FAIL rst_pending got %b exp 1", up.read_data_valid); end
    rest = 0;
    #1;
    checks++; if (up.read_data_valid !== 1'b0 || dut.cnt !== '0) begin errors++; $display("FAIL rst_flush got valid=%b cnt=%0d exp 0 0", up.read_data_valid, dut.cnt); end
    @(negedge clk); rest = 1; up.resp_ready = 1; sdat[1] = 32'h5151;
    @(negedge clk); cmd(1, 0, 32'h1000_0000, 0, 0, 0); #1;
    checks++; if (up.request_ready !== 1'b1 || rd_s !== 4'b0010) begin errors++; $display("FAIL rst_after_ready got ready=%b strobes=%b exp 1 0010", up.request_ready, rd_s); end
    @(negedge clk); idle();
    while (rx_n == b && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (rx_n - b != 1 || rx[b % 64] !== 32'h5151) begin errors++; $display("FAIL rst_after_data got %0d beats %h exp 1 beat 00005151", rx_n - b, rx[b % 64]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sdat[i] = 0;
    idle();
    up.resp_ready = 0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_pipelined();
    test_write_burst();
    test_err_burst();
    test_reset_outstanding();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
